// File: rtl/fpu_norm_round_pkg.sv
// Shared definitions for the FPU normalise/round stage: FSM states and flag bit positions.
package fpu_norm_round_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int FLG_OVF  = 3;
    localparam int FLG_UNF  = 2;
    localparam int FLG_INX  = 1;
    localparam int FLG_ZERO = 0;

endpackage

// File: rtl/fpu_norm_round_if.sv
// Input beat and result beat of the normalise/round stage, both valid/ready.
// Handshake: a beat transfers on a rising edge where valid and ready are both high;
// valid holds its data stable until that edge, and ready never depends on valid.
interface fpu_norm_round_if #(
    parameter int WIDTH  = 64,
    parameter int MANT_W = 53,
    parameter int EXP_W  = 11
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH:0]    in_mag;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [EXP_W-1:0]  out_exp;
    logic [MANT_W-1:0] out_mant;
    logic [3:0]        out_flags;

    modport master (
        output in_valid, in_mag, in_sign, in_exp, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_mant, out_flags
    );

    modport slave (
        input  in_valid, in_mag, in_sign, in_exp, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_mant, out_flags
    );
endinterface

// File: rtl/fpu_round_rne.sv
// Combinational round-to-nearest-even of a mantissa with guard/sticky bits.
// Shared by the add/sub, mul and div result paths.
module fpu_round_rne #(
    parameter int MANT_W = 53,
    parameter int EXP_W  = 11
) (
    input  logic [MANT_W-1:0] m_i,
    input  logic              g_i,
    input  logic              s_i,
    input  logic [EXP_W:0]    e_i,
    output logic [MANT_W-1:0] m_o,
    output logic [EXP_W:0]    e_o,
    output logic              inexact_o
);
    localparam logic [EXP_W:0] E_ONE = 1;

    logic          inc;
    logic [MANT_W:0] sum;

    assign inc       = g_i & (s_i | m_i[0]);
    assign sum       = {1'b0, m_i} + {{MANT_W{1'b0}}, inc};
    assign inexact_o = g_i | s_i;

    always_comb begin
        m_o = sum[MANT_W-1:0];
        e_o = e_i;
        if (sum[MANT_W]) begin
            m_o = {1'b1, {(MANT_W-1){1'b0}}};
            e_o = e_i + E_ONE;
        end else if (!m_i[MANT_W-1] && sum[MANT_W-1]) begin
            // A denormal that rounds up into the hidden bit becomes the smallest normal.
            e_o = E_ONE;
        end
    end
endmodule

// File: rtl/fpu_norm_round.sv
// Post-ALU normalise (1 bit per cycle) and round-to-nearest-even stage for FPU add/sub.
module fpu_norm_round
    import fpu_norm_round_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int MANT_W = 53,
    parameter int EXP_W  = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    fpu_norm_round_if.slave    bus,
    output state_t             dbg_state
);
    localparam int             GPOS    = WIDTH - 1 - MANT_W;
    localparam logic [EXP_W:0] E_ONE   = 1;
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    state_t            state_q, state_d;
    logic [WIDTH:0]    r_q, r_d;
    logic [EXP_W:0]    e_q, e_d;
    logic              sticky_q, sticky_d;
    logic              sign_q, sign_d;
    logic              zero_q, zero_d;
    logic              out_sign_q, out_sign_d;
    logic [EXP_W-1:0]  out_exp_q, out_exp_d;
    logic [MANT_W-1:0] out_mant_q, out_mant_d;
    logic [3:0]        out_flags_q, out_flags_d;

    logic [MANT_W-1:0] m_rnd;
    logic [EXP_W:0]    e_rnd;
    logic              inx;

    fpu_round_rne #(.MANT_W(MANT_W), .EXP_W(EXP_W)) u_round (
        .m_i       (r_q[WIDTH-1 -: MANT_W]),
        .g_i       (r_q[GPOS]),
        .s_i       (sticky_q | (|r_q[GPOS-1:0])),
        .e_i       (e_q),
        .m_o       (m_rnd),
        .e_o       (e_rnd),
        .inexact_o (inx)
    );

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        e_d         = e_q;
        sticky_d    = sticky_q;
        sign_d      = sign_q;
        zero_d      = zero_q;
        out_sign_d  = out_sign_q;
        out_exp_d   = out_exp_q;
        out_mant_d  = out_mant_q;
        out_flags_d = out_flags_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    r_d      = bus.in_mag;
                    e_d      = {1'b0, bus.in_exp};
                    sign_d   = bus.in_sign;
                    sticky_d = 1'b0;
                    zero_d   = 1'b0;
                    state_d  = NORM;
                end
            end
            NORM: begin
                if (r_q == '0) begin
                    zero_d  = 1'b1;
                    state_d = ROUND;
                end else if (r_q[WIDTH]) begin
                    sticky_d = sticky_q | r_q[0];
                    r_d      = r_q >> 1;
                    e_d      = e_q + E_ONE;
                    state_d  = ROUND;
                end else if (r_q[WIDTH-1] || (e_q <= E_ONE)) begin
                    state_d = ROUND;
                end else begin
                    r_d = r_q << 1;
                    e_d = e_q - E_ONE;
                end
            end
            ROUND: begin
                state_d     = DONE;
                out_flags_d = '0;
                out_sign_d  = sign_q;
                if (zero_q) begin
                    out_sign_d            = 1'b0;
                    out_exp_d             = '0;
                    out_mant_d            = '0;
                    out_flags_d[FLG_ZERO] = 1'b1;
                end else if (e_rnd >= EXP_MAX) begin
                    out_exp_d            = '1;
                    out_mant_d           = '0;
                    out_flags_d[FLG_OVF] = 1'b1;
                    out_flags_d[FLG_INX] = 1'b1;
                end else if (!m_rnd[MANT_W-1]) begin
                    // Still subnormal after rounding: biased exponent encodes as zero.
                    out_exp_d            = '0;
                    out_mant_d           = m_rnd;
                    out_flags_d[FLG_UNF] = inx;
                    out_flags_d[FLG_INX] = inx;
                end else begin
                    out_exp_d            = e_rnd[EXP_W-1:0];
                    out_mant_d           = m_rnd;
                    out_flags_d[FLG_INX] = inx;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            r_q         <= '0;
            e_q         <= '0;
            sticky_q    <= 1'b0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_mant_q  <= '0;
            out_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            e_q         <= e_d;
            sticky_q    <= sticky_d;
            sign_q      <= sign_d;
            zero_q      <= zero_d;
            out_sign_q  <= out_sign_d;
            out_exp_q   <= out_exp_d;
            out_mant_q  <= out_mant_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sign  = out_sign_q;
    assign bus.out_exp   = out_exp_q;
    assign bus.out_mant  = out_mant_q;
    assign bus.out_flags = out_flags_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_fpu_norm_round.sv
// Directed-vector bench for fpu_norm_round with hand-computed results.
module tb_fpu_norm_round;
  import fpu_norm_round_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     n_checks;
  int     n_pass;

  fpu_norm_round_if #(.WIDTH(64), .MANT_W(53), .EXP_W(11)) bus ();

  fpu_norm_round #(.WIDTH(64), .MANT_W(53), .EXP_W(11)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  // drive one beat, measure latency, check result, optionally stall, then handshake
  task automatic run_vec(input string tag, input logic [64:0] mag, input logic sgn,
                         input logic [10:0] ex, input int lat_exp, input logic e_sign,
                         input logic [10:0] e_exp, input logic [52:0] e_mant,
                         input logic [3:0] e_flags, input int hold);
    int lat;
    int waited;
    @(negedge clk);
    waited = 0;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_in_ready"}, 128'(bus.in_ready), 128'(1));
    bus.in_valid = 1'b1;
    bus.in_mag   = mag;
    bus.in_sign  = sgn;
    bus.in_exp   = ex;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'(lat_exp));
    check({tag, "_sign"}, 128'(bus.out_sign), 128'(e_sign));
    check({tag, "_exp"}, 128'(bus.out_exp), 128'(e_exp));
    check({tag, "_mant"}, 128'(bus.out_mant), 128'(e_mant));
    check({tag, "_flags"}, 128'(bus.out_flags), 128'(e_flags));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_mag   = 65'h0_1234_5678_9ABC_DEF0;
      bus.in_exp   = 11'd5;
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 128'(bus.out_valid), 128'(1));
      check({tag, "_hold_in_ready"}, 128'(bus.in_ready), 128'(0));
      check({tag, "_hold_mant"}, 128'(bus.out_mant), 128'(e_mant));
      check({tag, "_hold_exp"}, 128'(bus.out_exp), 128'(e_exp));
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, 128'(bus.out_valid), 128'(0));
    check({tag, "_back_idle"}, 128'(dbg_state), 128'(IDLE));
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mag    = '0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_out_mant", 128'(bus.out_mant), 128'(0));
    check("rst_out_flags", 128'(bus.out_flags), 128'(0));
    rst_n = 1'b1;

    // already normalised
    run_vec("norm", 65'h0_8000_0000_0000_0000, 1'b0, 11'd1023, 3,
            1'b0, 11'd1023, 53'h10_0000_0000_0000, 4'b0000, 0);
    // carry out, exact
    run_vec("carry", 65'h1_0000_0000_0000_0000, 1'b1, 11'd1023, 3,
            1'b1, 11'd1024, 53'h10_0000_0000_0000, 4'b0000, 0);
    // four left shifts
    run_vec("shift4", 65'h0_0800_0000_0000_0000, 1'b0, 11'd1023, 7,
            1'b0, 11'd1019, 53'h10_0000_0000_0000, 4'b0000, 0);
    // tie, stays even
    run_vec("tie_even", 65'h0_8000_0000_0000_0400, 1'b0, 11'd1023, 3,
            1'b0, 11'd1023, 53'h10_0000_0000_0000, 4'b0010, 0);
    // tie on odd, rounds up
    run_vec("tie_odd", 65'h0_8000_0000_0000_0C00, 1'b0, 11'd1023, 3,
            1'b0, 11'd1023, 53'h10_0000_0000_0002, 4'b0010, 0);
    // carry then overflow to Inf
    run_vec("overflow", 65'h1_FFFF_FFFF_FFFF_FFFF, 1'b0, 11'd2046, 3,
            1'b0, 11'd2047, 53'h0, 4'b1010, 0);
    // exact zero with negative sign
    run_vec("zero", 65'h0, 1'b1, 11'd1023, 3,
            1'b0, 11'd0, 53'h0, 4'b0001, 0);
    // denormal rounds up into the hidden bit
    run_vec("denorm_up", 65'h0_7FFF_FFFF_FFFF_FC00, 1'b0, 11'd1, 3,
            1'b0, 11'd1, 53'h10_0000_0000_0000, 4'b0010, 0);
    // inexact denormal stays denormal
    run_vec("denorm_unf", 65'h0_0000_0000_0000_0C01, 1'b1, 11'd1, 3,
            1'b1, 11'd0, 53'h2, 4'b0110, 0);
    // exact denormal, stalled downstream for 5 cycles
    run_vec("denorm_hold", 65'h0_0000_0000_0000_0800, 1'b0, 11'd1, 3,
            1'b0, 11'd0, 53'h1, 4'b0000, 5);

    // reset in the middle of a normalise sequence
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_mag   = 65'h0_0800_0000_0000_0000;
    bus.in_sign  = 1'b0;
    bus.in_exp   = 11'd1023;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_norm_state", 128'(dbg_state), 128'(NORM));
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("mid_rst_mant", 128'(bus.out_mant), 128'(0));
    check("mid_rst_flags", 128'(bus.out_flags), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("after_rst", 65'h0_8000_0000_0000_0000, 1'b0, 11'd1023, 3,
            1'b0, 11'd1023, 53'h10_0000_0000_0000, 4'b0000, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
